// File: rtl/canny_accel_hls_deadlock_pkg.sv
// Shared types for the dataflow deadlock report controller: FSM states and
// the process-index width helper.
package canny_accel_hls_deadlock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_REPORT = 3'd3,
        ST_ABORT  = 3'd4
    } dl_state_e;

    // Timeout counter width; covers TIMEOUT_CYCLES up to 65535.
    localparam int unsigned CNT_W = 16;

    // Width of a process index, never narrower than one bit.
    function automatic int unsigned proc_id_w(input int unsigned n);
        return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/canny_accel_hls_deadlock_prio_enc.sv
// Combinational lowest-index-first priority encoder: vector -> (valid, index).
module canny_accel_hls_deadlock_prio_enc #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     vec_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scan from the top down so the lowest set bit is the last to win.
    always_comb begin
        valid_o = |vec_i;
        idx_o   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/canny_accel_hls_deadlock_report_ctrl.sv
// Deadlock report controller: picks a flagged process, circulates a detection
// token from it and reports or aborts. Timeout logic is built only when
// CANNY_ACCEL_HLS_DEADLOCK_TIMEOUT_EN is defined.
module canny_accel_hls_deadlock_report_ctrl
    import canny_accel_hls_deadlock_pkg::*;
#(
    parameter int unsigned PROC_NUM       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [PROC_NUM-1:0]              dl_detect_vec,
    input  logic [PROC_NUM-1:0]              token_return_vec,
    input  logic                             deadlock_ack,
    output logic [PROC_NUM-1:0]              origin_vec,
    output logic                             dl_detect_in,
    output logic                             token_clear,
    output logic                             deadlock_valid,
    output logic [proc_id_w(PROC_NUM)-1:0]   deadlock_proc_id,
    output logic                             timeout_pulse
);

    localparam int unsigned ID_W = proc_id_w(PROC_NUM);

    dl_state_e           state_q, state_d;
    logic [ID_W-1:0]     sel_q, sel_d;
    logic [PROC_NUM-1:0] det_q;
    logic [PROC_NUM-1:0] origin_q, origin_d;
    logic                dl_in_q, dl_in_d;
    logic                tclr_q, tclr_d;
    logic                valid_q, valid_d;
    logic [ID_W-1:0]     pid_q, pid_d;
    logic                enc_valid;
    logic [ID_W-1:0]     enc_idx;

`ifdef CANNY_ACCEL_HLS_DEADLOCK_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tout_q, tout_d;
`else
    logic unused_cfg_c;
    assign unused_cfg_c = ^32'(TIMEOUT_CYCLES);
`endif

    canny_accel_hls_deadlock_prio_enc #(
        .N     (PROC_NUM),
        .IDX_W (ID_W)
    ) u_prio_enc (
        .vec_i   (det_q),
        .valid_o (enc_valid),
        .idx_o   (enc_idx)
    );

    // Next-state and registered-output decode; outputs follow state_d.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        origin_d = '0;
        dl_in_d  = 1'b0;
        tclr_d   = 1'b0;
        valid_d  = 1'b0;
        pid_d    = '0;
`ifdef CANNY_ACCEL_HLS_DEADLOCK_TIMEOUT_EN
        cnt_d    = cnt_q;
        tout_d   = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
`ifdef CANNY_ACCEL_HLS_DEADLOCK_TIMEOUT_EN
                cnt_d = '0;
`endif
                if (enc_valid) begin
                    sel_d   = enc_idx;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
`ifdef CANNY_ACCEL_HLS_DEADLOCK_TIMEOUT_EN
                cnt_d = '0;
`endif
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
`ifdef CANNY_ACCEL_HLS_DEADLOCK_TIMEOUT_EN
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
                // A return in the last counted cycle still beats the timeout.
                if (token_return_vec[sel_q]) begin
                    state_d = ST_REPORT;
                end
`ifdef CANNY_ACCEL_HLS_DEADLOCK_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d = ST_ABORT;
                end
`endif
            end
            ST_REPORT: begin
                if (deadlock_ack) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ABORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case (state_d)
            ST_ISSUE: begin
                origin_d = PROC_NUM'(1) << sel_d;
                dl_in_d  = 1'b1;
            end
            ST_WAIT: begin
                dl_in_d = 1'b1;
            end
            ST_REPORT: begin
                dl_in_d = 1'b1;
                valid_d = 1'b1;
                pid_d   = sel_d;
                tclr_d  = (state_q == ST_WAIT);
            end
            ST_ABORT: begin
                tclr_d = 1'b1;
`ifdef CANNY_ACCEL_HLS_DEADLOCK_TIMEOUT_EN
                tout_d = 1'b1;
`endif
            end
            default: begin
                origin_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            det_q    <= '0;
            origin_q <= '0;
            dl_in_q  <= 1'b0;
            tclr_q   <= 1'b0;
            valid_q  <= 1'b0;
            pid_q    <= '0;
`ifdef CANNY_ACCEL_HLS_DEADLOCK_TIMEOUT_EN
            cnt_q    <= '0;
            tout_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            det_q    <= dl_detect_vec;
            origin_q <= origin_d;
            dl_in_q  <= dl_in_d;
            tclr_q   <= tclr_d;
            valid_q  <= valid_d;
            pid_q    <= pid_d;
`ifdef CANNY_ACCEL_HLS_DEADLOCK_TIMEOUT_EN
            cnt_q    <= cnt_d;
            tout_q   <= tout_d;
`endif
        end
    end

    assign origin_vec       = origin_q;
    assign dl_detect_in     = dl_in_q;
    assign token_clear      = tclr_q;
    assign deadlock_valid   = valid_q;
    assign deadlock_proc_id = pid_q;
`ifdef CANNY_ACCEL_HLS_DEADLOCK_TIMEOUT_EN
    assign timeout_pulse    = tout_q;
`else
    assign timeout_pulse    = 1'b0;
`endif

endmodule

// File: tb/tb_canny_accel_hls_deadlock_report_ctrl.sv
// Bench for canny_accel_hls_deadlock_report_ctrl (PROC_NUM=4, TIMEOUT_CYCLES=8);
// expectations follow CANNY_ACCEL_HLS_DEADLOCK_TIMEOUT_EN when defined.
module tb_canny_accel_hls_deadlock_report_ctrl;

    typedef struct packed {
        logic [3:0] org;
        logic       dli;
        logic       tclr;
        logic       vld;
        logic [1:0] pid;
        logic       tout;
    } out_t;

    typedef struct {
        string       tag;
        int unsigned n;
        logic [3:0]  det;
        logic [3:0]  ret;
        logic        ack;
        out_t        exp;
    } row_t;

    logic       clock;
    logic       reset;
    logic [3:0] dl_detect_vec;
    logic [3:0] token_return_vec;
    logic       deadlock_ack;
    logic [3:0] origin_vec;
    logic       dl_detect_in;
    logic       token_clear;
    logic       deadlock_valid;
    logic [1:0] deadlock_proc_id;
    logic       timeout_pulse;

    int   n_vec;
    int   n_err;
    int   cyc;
    out_t sb_q[$];
    row_t tab[$];

    canny_accel_hls_deadlock_report_ctrl #(
        .PROC_NUM       (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .dl_detect_vec    (dl_detect_vec),
        .token_return_vec (token_return_vec),
        .deadlock_ack     (deadlock_ack),
        .origin_vec       (origin_vec),
        .dl_detect_in     (dl_detect_in),
        .token_clear      (token_clear),
        .deadlock_valid   (deadlock_valid),
        .deadlock_proc_id (deadlock_proc_id),
        .timeout_pulse    (timeout_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic out_t o(input logic [3:0] org, input logic dli, input logic tclr,
                               input logic vld, input logic [1:0] pid, input logic tout);
        out_t x;
        x.org = org; x.dli = dli; x.tclr = tclr; x.vld = vld; x.pid = pid; x.tout = tout;
        return x;
    endfunction

    function automatic row_t r(input string tag, input int unsigned n, input logic [3:0] det,
                               input logic [3:0] ret, input logic ack, input out_t exp);
        row_t x;
        x.tag = tag; x.n = n; x.det = det; x.ret = ret; x.ack = ack; x.exp = exp;
        return x;
    endfunction

    // One cycle: drive after the edge, queue the expectation, check on the falling edge.
    task automatic step(input string tag, input logic rst, input logic [3:0] det,
                        input logic [3:0] ret, input logic ack, input out_t exp);
        out_t want;
        out_t got;
        @(posedge clock);
        #1;
        reset            = rst;
        dl_detect_vec    = det;
        token_return_vec = ret;
        deadlock_ack     = ack;
        sb_q.push_back(exp);
        @(negedge clock);
        want = sb_q.pop_front();
        got  = {origin_vec, dl_detect_in, token_clear, deadlock_valid, deadlock_proc_id, timeout_pulse};
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s cyc%0d: got org=%b dli=%b tclr=%b vld=%b pid=%0d tout=%b, want org=%b dli=%b tclr=%b vld=%b pid=%0d tout=%b",
                     tag, cyc, got.org, got.dli, got.tclr, got.vld, got.pid, got.tout,
                     want.org, want.dli, want.tclr, want.vld, want.pid, want.tout);
        end
        cyc++;
    endtask

    localparam logic [3:0] Z4 = 4'b0000;

    initial begin
        out_t zero;
        zero             = o(Z4, 0, 0, 0, 2'd0, 0);
        n_vec            = 0;
        n_err            = 0;
        cyc              = 0;
        reset            = 1'b0;
        dl_detect_vec    = '0;
        token_return_vec = '0;
        deadlock_ack     = 1'b0;

        // Single-process detect, return at cycle 5, report at cycle 6.
        tab.push_back(r("basic", 1, 4'b0100, Z4, 0, zero));
        tab.push_back(r("basic", 1, Z4, Z4, 0, zero));
        tab.push_back(r("basic", 1, Z4, Z4, 0, o(4'b0100, 1, 0, 0, 2'd0, 0)));
        tab.push_back(r("basic", 2, Z4, Z4, 0, o(Z4, 1, 0, 0, 2'd0, 0)));
        tab.push_back(r("basic", 1, Z4, 4'b0100, 0, o(Z4, 1, 0, 0, 2'd0, 0)));
        tab.push_back(r("basic", 1, Z4, Z4, 0, o(Z4, 1, 1, 1, 2'd2, 0)));
        tab.push_back(r("basic", 1, Z4, Z4, 1, o(Z4, 1, 0, 1, 2'd2, 0)));
        tab.push_back(r("basic", 1, Z4, Z4, 0, zero));
        // Lowest index wins, late detect changes, foreign returns and early ack ignored.
        tab.push_back(r("prio", 1, 4'b1010, Z4, 0, zero));
        tab.push_back(r("prio", 1, Z4, Z4, 0, zero));
        tab.push_back(r("prio", 1, 4'b0001, Z4, 0, o(4'b0010, 1, 0, 0, 2'd0, 0)));
        tab.push_back(r("prio", 1, Z4, 4'b1000, 1, o(Z4, 1, 0, 0, 2'd0, 0)));
        tab.push_back(r("prio", 1, Z4, 4'b1000, 0, o(Z4, 1, 0, 0, 2'd0, 0)));
        tab.push_back(r("prio", 1, Z4, 4'b0010, 0, o(Z4, 1, 0, 0, 2'd0, 0)));
        tab.push_back(r("prio", 1, Z4, Z4, 1, o(Z4, 1, 1, 1, 2'd1, 0)));
        tab.push_back(r("prio", 2, Z4, Z4, 0, zero));
`ifdef CANNY_ACCEL_HLS_DEADLOCK_TIMEOUT_EN
        // No return: 8 wait cycles, then a single abort cycle.
        tab.push_back(r("abort", 1, 4'b0001, Z4, 0, zero));
        tab.push_back(r("abort", 1, Z4, Z4, 0, zero));
        tab.push_back(r("abort", 1, Z4, Z4, 0, o(4'b0001, 1, 0, 0, 2'd0, 0)));
        tab.push_back(r("abort", 8, Z4, Z4, 0, o(Z4, 1, 0, 0, 2'd0, 0)));
        tab.push_back(r("abort", 1, Z4, Z4, 0, o(Z4, 0, 1, 0, 2'd0, 1)));
        tab.push_back(r("abort", 2, Z4, Z4, 0, zero));
        // Return in the final counted cycle wins over the timeout.
        tab.push_back(r("race", 1, 4'b1000, Z4, 0, zero));
        tab.push_back(r("race", 1, Z4, Z4, 0, zero));
        tab.push_back(r("race", 1, Z4, Z4, 0, o(4'b1000, 1, 0, 0, 2'd0, 0)));
        tab.push_back(r("race", 7, Z4, Z4, 0, o(Z4, 1, 0, 0, 2'd0, 0)));
        tab.push_back(r("race", 1, Z4, 4'b1000, 0, o(Z4, 1, 0, 0, 2'd0, 0)));
        tab.push_back(r("race", 1, Z4, Z4, 1, o(Z4, 1, 1, 1, 2'd3, 0)));
        tab.push_back(r("race", 2, Z4, Z4, 0, zero));
`else
        // Without the timeout the wait is unbounded.
        tab.push_back(r("nolimit", 1, 4'b0001, Z4, 0, zero));
        tab.push_back(r("nolimit", 1, Z4, Z4, 0, zero));
        tab.push_back(r("nolimit", 1, Z4, Z4, 0, o(4'b0001, 1, 0, 0, 2'd0, 0)));
        tab.push_back(r("nolimit", 100, Z4, Z4, 0, o(Z4, 1, 0, 0, 2'd0, 0)));
        tab.push_back(r("nolimit", 1, Z4, 4'b0001, 0, o(Z4, 1, 0, 0, 2'd0, 0)));
        tab.push_back(r("nolimit", 1, Z4, Z4, 1, o(Z4, 1, 1, 1, 2'd0, 0)));
        tab.push_back(r("nolimit", 2, Z4, Z4, 0, zero));
`endif

        repeat (2) @(posedge clock);
        step("reset", 1'b0, Z4, Z4, 0, zero);
        cyc = 0;

        foreach (tab[i]) begin
            for (int k = 0; k < int'(tab[i].n); k++) begin
                step(tab[i].tag, 1'b1, tab[i].det, tab[i].ret, tab[i].ack, tab[i].exp);
            end
        end

        // Reset while a report is held, then confirm a clean restart from idle.
        cyc = 0;
        step("rst_rep", 1'b1, 4'b0010, Z4, 0, zero);
        step("rst_rep", 1'b1, Z4, Z4, 0, zero);
        step("rst_rep", 1'b1, Z4, Z4, 0, o(4'b0010, 1, 0, 0, 2'd0, 0));
        step("rst_rep", 1'b1, Z4, 4'b0010, 0, o(Z4, 1, 0, 0, 2'd0, 0));
        step("rst_rep", 1'b1, Z4, Z4, 0, o(Z4, 1, 1, 1, 2'd1, 0));
        step("rst_rep", 1'b0, Z4, Z4, 0, o(Z4, 1, 0, 1, 2'd1, 0));
        step("rst_rep", 1'b1, Z4, Z4, 1, zero);
        step("rst_rep", 1'b1, Z4, Z4, 1, zero);
        step("rst_rep", 1'b1, 4'b0001, Z4, 0, zero);
        step("rst_rep", 1'b1, Z4, Z4, 0, zero);
        step("rst_rep", 1'b1, Z4, Z4, 0, o(4'b0001, 1, 0, 0, 2'd0, 0));
        step("rst_rep", 1'b1, Z4, Z4, 0, o(Z4, 1, 0, 0, 2'd0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/canny_accel_hls_deadlock_report_ctrl.md
CANNY_ACCEL_HLS_DEADLOCK_REPORT_CTRL -- requirements
Module: canny_accel_hls_deadlock_report_ctrl

Interface
REQ-001 Parameter PROC_NUM, default 4, number of dataflow processes monitored.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, max cycles to wait for token return; 2..65535.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-low reset; one clock; reset is synchronous and active-low.
REQ-005 dl_detect_vec  input  PROC_NUM  per-process dl_detect_out from the detect units.
REQ-006 token_return_vec  input  PROC_NUM  per-process OR of token_in_vec.
REQ-007 deadlock_ack  input  1  consumer acknowledge of a report.
REQ-008 origin_vec  output  PROC_NUM  one-hot origin strobe to the selected detect unit.
REQ-009 dl_detect_in  output  1  broadcast "detection in progress" to all detect units.
REQ-010 token_clear  output  1  one-cycle token flush strobe to all detect units.
REQ-011 deadlock_valid  output  1  confirmed-deadlock report valid.
REQ-012 deadlock_proc_id  output  clog2(PROC_NUM) (min 1)  index of reporting process.
REQ-013 timeout_pulse  output  1  one-cycle strobe on aborted detection.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, WAIT, REPORT, ABORT; all outputs registered.
REQ-015 IDLE: if |dl_detect_vec, latch sel_id = lowest set index, go ISSUE next cycle; else stay.
REQ-016 ISSUE (exactly 1 cycle): origin_vec = 1<<sel_id, dl_detect_in=1, counter cleared; go WAIT.
REQ-017 WAIT: dl_detect_in=1, origin_vec=0; counter increments each cycle, saturating at TIMEOUT_CYCLES-1.
REQ-018 WAIT: token_return_vec[sel_id]=1 -> REPORT; token_clear=1 for the first REPORT cycle only.
REQ-019 WAIT: counter==TIMEOUT_CYCLES-1 with no return -> ABORT; return wins if both occur in the same cycle.
REQ-020 Token returns on indices other than sel_id SHALL be ignored.
REQ-021 REPORT: deadlock_valid=1, deadlock_proc_id=sel_id, dl_detect_in=1, held stable until deadlock_ack sampled high; then IDLE.
REQ-022 deadlock_ack outside REPORT SHALL be ignored; ack in the first REPORT cycle is honoured (valid for 1 cycle).
REQ-023 ABORT (exactly 1 cycle): token_clear=1, timeout_pulse=1, dl_detect_in=0; go IDLE.
REQ-024 dl_detect_vec changes after sel_id latch SHALL NOT alter sel_id for that detection.
REQ-025 Latency: dl_detect_vec rise in IDLE -> origin_vec pulse 2 cycles later.

Reset
REQ-026 reset low at a rising edge SHALL force IDLE, counter=0, sel_id=0, all outputs 0, incl. mid-WAIT/REPORT; no token_clear generated by reset.

Configuration
REQ-027 Macro CANNY_ACCEL_HLS_DEADLOCK_TIMEOUT_EN defined: counter, ABORT state and REQ-019 present.
REQ-028 Macro undefined: no counter, WAIT unbounded, ABORT unreachable, timeout_pulse tied 0, TIMEOUT_CYCLES ignored.

Structure
REQ-029 Shared package canny_accel_hls_deadlock_pkg SHALL hold the FSM state typedef and the PROC_ID width function.
REQ-030 Sub-module canny_accel_hls_deadlock_prio_enc: combinational lowest-index-first encoder (vector -> valid, index).

Verification (PROC_NUM=4, TIMEOUT_CYCLES=8, macro defined unless stated)
REQ-031 dl_detect_vec=4'b0100 at cycle 0, token_return_vec[2] at cycle 5 -> origin_vec=4'b0100 at cycle 2, token_clear and deadlock_valid at cycle 6, proc_id=2.
REQ-032 dl_detect_vec=4'b1010 -> sel_id=1, origin_vec=4'b0010; token_return_vec=4'b1000 in WAIT ignored.
REQ-033 No return -> after 8 WAIT cycles ABORT: token_clear=timeout_pulse=1 for 1 cycle, dl_detect_in=0, back to IDLE.
REQ-034 Return coincident with final timeout cycle -> REPORT, timeout_pulse stays 0.
REQ-035 reset low during REPORT with deadlock_valid=1 -> next cycle all outputs 0, state IDLE.
REQ-036 Macro undefined, no return for 100 cycles -> stays WAIT, dl_detect_in=1, timeout_pulse never 1.
